keccak_sponge_ctrl: RTL

Parametrised sponge controller sequencing a Keccak-f permutation core and its message/state datapath through multi-block absorb and multi-block squeeze phases. It is the successor to the single-squeeze hash controller. Block counting is internal, rate/capacity/digest sizes are generic, and completion is held until acknowledged. It sits between the hash front-end (start/ack) and the permutation datapath (load/xor/shift/capture strobes).

---
 rtl/keccak_sponge_ctrl.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/keccak_sponge_ctrl.sv
// rtl/keccak_sponge_ctrl.sv - Keccak sponge absorb/squeeze sequencing controller
//
// Purpose:
//    Moore FSM that sequences a Keccak-f permutation core and its message/state
//    datapath through N_ABS absorb blocks (pad10*1 included) followed by M_SQ
//    squeeze blocks. Completion (o_done) and watchdog error (o_err) are held
//    until i_ack. All strobes are registered and decoded from the next state,
//    so each strobe is high exactly while the FSM sits in its state.
//
// Ports:
//    i_clk          clock, rising edge
//    i_rst_n        asynchronous active-low reset
//    i_start        start request (acted on in IDLE only)
//    i_ack          acknowledge for o_done / o_err
//    i_f_done       permutation finished (acted on in wait states only)
//    o_f_start      one-cycle permutation start strobe
//    o_load_msg     load padded message into P register
//    o_xor_block    XOR current R-bit block into state
//    o_shift_msg    shift P by R bits
//    o_capture_out  capture R bits of state into output slot o_out_idx
//    o_out_idx      squeeze block index (CW bits)
//    o_clr_state    clear datapath state (IDLE and ERROR)
//    o_busy         high outside IDLE, DONE and ERROR
//    o_done         digest valid, held until i_ack
//    o_err          watchdog error, held until i_ack
//
// Configuration:
//    KECCAK_CTRL_WDOG_EN  when defined, a wait state that lasts WDOG_CYCLES
//                         cycles without i_f_done moves the FSM to ERROR.
//                         When undefined, waits are unbounded and o_err is 0.

module keccak_sponge_ctrl #(
   parameter  int L           = 160,
   parameter  int D           = 128,
   parameter  int B           = 400,
   parameter  int R           = 128,
   parameter  int WDOG_CYCLES = 64,
   localparam int N_ABS       = (L + 2 + R - 1) / R,
   localparam int M_SQ        = (D + R - 1) / R,
   localparam int CNT_MAX     = (N_ABS > M_SQ) ? N_ABS : M_SQ,
   localparam int CW          = $clog2(CNT_MAX + 1)
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_start,
   input  logic          i_ack,
   input  logic          i_f_done,
   output logic          o_f_start,
   output logic          o_load_msg,
   output logic          o_xor_block,
   output logic          o_shift_msg,
   output logic          o_capture_out,
   output logic [CW-1:0] o_out_idx,
   output logic          o_clr_state,
   output logic          o_busy,
   output logic          o_done,
   output logic          o_err
);

   // Elaboration-time sanity check of the sponge geometry (capacity B-R > 0).
   if (R <= 0 || R >= B || WDOG_CYCLES < 1) begin : g_bad_cfg
      $error("keccak_sponge_ctrl: need 0 < R < B and WDOG_CYCLES >= 1");
   end

   typedef enum logic [3:0] {
      S_IDLE,
      S_LOAD,
      S_ABS_XOR,
      S_ABS_START,
      S_ABS_WAIT,
      S_ABS_NEXT,
      S_SQ_CAPTURE,
      S_SQ_START,
      S_SQ_WAIT,
      S_DONE,
      S_ERROR
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] abs_cnt_q, abs_cnt_d;
   logic [CW-1:0] sq_cnt_q, sq_cnt_d;
   logic [CW:0]   abs_inc, sq_inc;
   logic          wdog_expired;

   logic f_start_q, f_start_d;
   logic load_q, load_d;
   logic xor_q, xor_d;
   logic shift_q, shift_d;
   logic cap_q, cap_d;
   logic clr_q, clr_d;
   logic busy_q, busy_d;
   logic done_q, done_d;

   // One extra bit so the +1 can never wrap before the terminal compare.
   assign abs_inc = {1'b0, abs_cnt_q} + {{CW{1'b0}}, 1'b1};
   assign sq_inc  = {1'b0, sq_cnt_q} + {{CW{1'b0}}, 1'b1};

`ifdef KECCAK_CTRL_WDOG_EN
   localparam int WW = $clog2(WDOG_CYCLES + 1);

   logic [WW-1:0] wdog_q, wdog_d;
   logic          err_q, err_d;

   // wdog_q counts wait cycles already spent; it is 0 in the first wait
   // cycle because every wait state is entered from a START state.
   always_comb begin
      wdog_d = '0;
      if (state_q == S_ABS_WAIT || state_q == S_SQ_WAIT) begin
         wdog_d = (wdog_q == WW'(WDOG_CYCLES)) ? wdog_q : wdog_q + WW'(1);
      end
   end

   assign wdog_expired = (wdog_q >= WW'(WDOG_CYCLES - 1));
   assign o_err        = err_q;
`else
   assign wdog_expired = 1'b0;
   assign o_err        = 1'b0;
`endif

   // Next-state and counter logic.
   always_comb begin
      state_d   = state_q;
      abs_cnt_d = abs_cnt_q;
      sq_cnt_d  = sq_cnt_q;
      unique case (state_q)
         S_IDLE: begin
            if (i_start) begin
               state_d   = S_LOAD;
               abs_cnt_d = '0;
               sq_cnt_d  = '0;
            end
         end
         S_LOAD:      state_d = S_ABS_XOR;
         S_ABS_XOR:   state_d = S_ABS_START;
         S_ABS_START: state_d = S_ABS_WAIT;
         S_ABS_WAIT: begin
            // A done arriving in the expiry cycle still wins.
            if (i_f_done)          state_d = S_ABS_NEXT;
            else if (wdog_expired) state_d = S_ERROR;
         end
         S_ABS_NEXT: begin
            if (abs_cnt_q != CW'(N_ABS)) abs_cnt_d = abs_inc[CW-1:0];
            state_d = (abs_inc >= (CW+1)'(N_ABS)) ? S_SQ_CAPTURE : S_ABS_XOR;
         end
         S_SQ_CAPTURE: begin
            if (sq_cnt_q != CW'(M_SQ)) sq_cnt_d = sq_inc[CW-1:0];
            state_d = (sq_inc >= (CW+1)'(M_SQ)) ? S_DONE : S_SQ_START;
         end
         S_SQ_START:  state_d = S_SQ_WAIT;
         S_SQ_WAIT: begin
            if (i_f_done)          state_d = S_SQ_CAPTURE;
            else if (wdog_expired) state_d = S_ERROR;
         end
         S_DONE:  if (i_ack) state_d = S_IDLE;
         S_ERROR: if (i_ack) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs are decoded from the next state and registered, so they line up
   // with the state register without any combinational path from inputs.
   always_comb begin
      f_start_d = (state_d == S_ABS_START) || (state_d == S_SQ_START);
      load_d    = (state_d == S_LOAD);
      xor_d     = (state_d == S_ABS_XOR);
      shift_d   = (state_d == S_ABS_NEXT);
      cap_d     = (state_d == S_SQ_CAPTURE);
      clr_d     = (state_d == S_IDLE) || (state_d == S_ERROR);
      busy_d    = !((state_d == S_IDLE) || (state_d == S_DONE) ||
                    (state_d == S_ERROR));
      done_d    = (state_d == S_DONE);
`ifdef KECCAK_CTRL_WDOG_EN
      err_d     = (state_d == S_ERROR);
`endif
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= S_IDLE;
         abs_cnt_q <= '0;
         sq_cnt_q  <= '0;
         f_start_q <= 1'b0;
         load_q    <= 1'b0;
         xor_q     <= 1'b0;
         shift_q   <= 1'b0;
         cap_q     <= 1'b0;
         clr_q     <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
`ifdef KECCAK_CTRL_WDOG_EN
         wdog_q    <= '0;
         err_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         abs_cnt_q <= abs_cnt_d;
         sq_cnt_q  <= sq_cnt_d;
         f_start_q <= f_start_d;
         load_q    <= load_d;
         xor_q     <= xor_d;
         shift_q   <= shift_d;
         cap_q     <= cap_d;
         clr_q     <= clr_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
`ifdef KECCAK_CTRL_WDOG_EN
         wdog_q    <= wdog_d;
         err_q     <= err_d;
`endif
      end
   end

   // The squeeze counter only advances on leaving SQ_CAPTURE, so during a
   // capture it holds exactly the slot being written.
   assign o_out_idx     = sq_cnt_q;
   assign o_f_start     = f_start_q;
   assign o_load_msg    = load_q;
   assign o_xor_block   = xor_q;
   assign o_shift_msg   = shift_q;
   assign o_capture_out = cap_q;
   assign o_clr_state   = clr_q;
   assign o_busy        = busy_q;
   assign o_done        = done_q;

endmodule
